ex_mult_hilo: RTL



---
 rtl/ex_mult_hilo.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ex_mult_hilo.sv
// ex_mult_hilo -- iterative shift-add 32x32 multiplier with the HI/LO pair.
//
// Sits beside the EX-stage ALU. MULT/MULTU run one shift-add step per cycle
// on operand magnitudes, and the sign is applied in a final FIX cycle.
// MTHI/MTLO writes are accepted only while idle. HI/LO always read the last
// committed value.
//
// Ports:
//   Clk, Reset_n        clock (rising edge), asynchronous active-low reset
//   Start_EX, Signed_EX start a multiply (sampled in IDLE), 1 = MULT, 0 = MULTU
//   Operand_A_EX/B_EX   multiplicand (rs) / multiplier (rt)
//   Write_HI_EX/LO_EX   MTHI / MTLO strobes, data on Write_Data_EX
//   HI_EX, LO_EX        registered HI / LO
//   Busy_EX             multiply in progress (pipeline stall source)
//   Done_EX             one-cycle pulse when HI/LO take a product
//
// Build option: define MULT_EARLY_EXIT_EN to leave CALC as soon as the
// remaining multiplier bits are all zero.
//
// state  | meaning
// IDLE   | waiting; accepts Start_EX or MTHI/MTLO
// CALC   | one shift-add step per cycle
// FIX    | apply sign, commit product to HI/LO, pulse Done_EX

module ex_mult_hilo #(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start_EX,
   input  logic             Signed_EX,
   input  logic [WIDTH-1:0] Operand_A_EX,
   input  logic [WIDTH-1:0] Operand_B_EX,
   input  logic             Write_HI_EX,
   input  logic             Write_LO_EX,
   input  logic [WIDTH-1:0] Write_Data_EX,
   output logic [WIDTH-1:0] HI_EX,
   output logic [WIDTH-1:0] LO_EX,
   output logic             Busy_EX,
   output logic             Done_EX
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;

   logic [WIDTH-1:0]     r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [2*WIDTH-1:0]   r_acc;
   logic [CW-1:0]        r_cnt;
   logic                 r_neg;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;
   logic                 r_done;

   logic                 w_start;
   logic [WIDTH-1:0]     w_mag_a;
   logic [WIDTH-1:0]     w_mag_b;
   logic [WIDTH-1:0]     w_addend;
   logic [WIDTH:0]       w_sum;
   logic [2*WIDTH-1:0]   w_step_acc;
   logic [2*WIDTH-1:0]   w_calc_acc;
   logic [WIDTH-1:0]     w_mplier_sh;
   logic                 w_last;
   logic                 w_exit;
   logic [2*WIDTH-1:0]   w_result;

   assign w_start = (r_state == S_IDLE) && Start_EX;

   // Magnitudes for MULT. The most negative value maps onto itself, which is
   // exactly its magnitude when read as unsigned.
   assign w_mag_a = (Signed_EX && Operand_A_EX[WIDTH-1]) ?
                    (~Operand_A_EX + {{(WIDTH-1){1'b0}}, 1'b1}) : Operand_A_EX;
   assign w_mag_b = (Signed_EX && Operand_B_EX[WIDTH-1]) ?
                    (~Operand_B_EX + {{(WIDTH-1){1'b0}}, 1'b1}) : Operand_B_EX;

   // One step: add into the upper half, then shift {carry, acc} right by one.
   assign w_addend    = r_mplier[0] ? r_mcand : '0;
   assign w_sum       = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
   assign w_step_acc  = {w_sum, r_acc[WIDTH-1:1]};
   assign w_mplier_sh = r_mplier >> 1;
   assign w_last      = (r_cnt == CW'(WIDTH-1));

`ifdef MULT_EARLY_EXIT_EN
   logic [CW-1:0] w_rem;

   // Steps still owed after this one; with no multiplier bits left they add
   // nothing, so only their shifts remain and are applied in one go.
   assign w_rem      = CW'(WIDTH-1) - r_cnt;
   assign w_exit     = w_last || (w_mplier_sh == '0);
   assign w_calc_acc = (w_mplier_sh == '0) ? (w_step_acc >> w_rem) : w_step_acc;
`else
   assign w_exit     = w_last;
   assign w_calc_acc = w_step_acc;
`endif

   assign w_result = r_neg ? (~r_acc + {{(2*WIDTH-1){1'b0}}, 1'b1}) : r_acc;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (Start_EX) w_state_nxt = S_CALC;
         S_CALC:  if (w_exit)   w_state_nxt = S_FIX;
         S_FIX:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_neg    <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_mcand  <= w_mag_a;
                  r_mplier <= w_mag_b;
                  r_neg    <= Signed_EX && (Operand_A_EX[WIDTH-1] ^ Operand_B_EX[WIDTH-1]);
                  r_acc    <= '0;
                  r_cnt    <= '0;
               end else begin
                  if (Write_HI_EX) r_hi <= Write_Data_EX;
                  if (Write_LO_EX) r_lo <= Write_Data_EX;
               end
            end
            S_CALC: begin
               r_acc    <= w_calc_acc;
               r_mplier <= w_mplier_sh;
               r_cnt    <= r_cnt + 1'b1;
            end
            S_FIX: begin
               r_hi   <= w_result[2*WIDTH-1:WIDTH];
               r_lo   <= w_result[WIDTH-1:0];
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign HI_EX   = r_hi;
   assign LO_EX   = r_lo;
   assign Busy_EX = (r_state != S_IDLE);
   assign Done_EX = r_done;

endmodule
